// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit decoder for
// the sequential Booth multiplier family.
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        OP     = 3'd2,
        SHIFT  = 3'd3,
        NOTIFY = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        B_NOP  = 3'd0,
        B_ADD1 = 3'd1,
        B_ADD2 = 3'd2,
        B_SUB1 = 3'd3,
        B_SUB2 = 3'd4
    } booth_op_e;

    // Map {b[2i+1], b[2i], b[2i-1]} to the Booth digit action.
    function automatic booth_op_e booth_decode(
        input logic [2:0] trip
    );
        booth_op_e op;
        case (trip)
            3'b001, 3'b010: op = B_ADD1;
            3'b011:         op = B_ADD2;
            3'b100:         op = B_SUB2;
            3'b101, 3'b110: op = B_SUB1;
            default:        op = B_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth4_recoder.sv
// Radix-4 Booth recoder: one multiplier triplet in,
// the add/subtract action for that digit out.
module booth4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] trip,
    output booth_op_e  op
);

    assign op = booth_decode(trip);

endmodule

// File: rtl/booth4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one OP/SHIFT pair
// per Booth digit, START/FINMULT four-phase handshake.
module booth4_seq_mult
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           START,
    input  logic           SIGNED_MODE,
    input  logic           ABORT,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           BUSY,
    output logic           FINMULT,
    output logic [2*N-1:0] P
);

    localparam int ITER  = N / 2 + 1;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int EW    = N + 2;
    localparam int SW    = 2 * N + 5;
    localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);

    if ((N % 2) != 0 || N < 4) begin : g_bad_n
        $error("booth4_seq_mult: N must be even and >= 4");
    end

    state_e           state_q, state_d;
    logic [EW-1:0]    m_q, m_d;
    logic [EW-1:0]    b_q, b_d;
    logic [EW-1:0]    hi_q, hi_d;
    logic [EW-1:0]    lo_q, lo_d;
    logic             qm1_q, qm1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   p_q, p_d;

    booth_op_e        op;
    logic [EW:0]      m3;
    logic [EW:0]      addend;
    logic [EW:0]      sum;
    logic [SW-1:0]    cat;
    logic [SW-1:0]    shifted;

    booth4_recoder u_recoder (
        .trip ({lo_q[1], lo_q[0], qm1_q}),
        .op   (op)
    );

    // Partial-product add at N+3 bits and the 2-bit arithmetic shift.
    always_comb begin
        m3      = {m_q[EW-1], m_q};
        addend  = '0;
        case (op)
            B_ADD1:  addend = m3;
            B_ADD2:  addend = m3 << 1;
            B_SUB1:  addend = -m3;
            B_SUB2:  addend = -(m3 << 1);
            default: addend = '0;
        endcase
        sum     = {hi_q[EW-1], hi_q} + addend;
        cat     = {hi_q, lo_q, qm1_q};
        shifted = $signed(cat) >>> 2;
    end

    // Controller and next-state datapath; ABORT overrides every state.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        if (ABORT) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        m_d = {{2{SIGNED_MODE & A[N-1]}}, A};
                        b_d = {{2{SIGNED_MODE & B[N-1]}}, B};
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    hi_d    = '0;
                    lo_d    = b_q;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = OP;
                end
                OP: begin
                    hi_d    = sum[EW-1:0];
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    {hi_d, lo_d, qm1_d} = shifted;
                    if (cnt_q == ITER_C) begin
                        p_d     = shifted[2*N:1];
                        state_d = NOTIFY;
                    end else begin
                        state_d = OP;
                    end
                end
                NOTIFY: begin
                    if (!START) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared by the async reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            m_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign BUSY    = (state_q == LOAD) || (state_q == OP) ||
                     (state_q == SHIFT);
    assign FINMULT = (state_q == NOTIFY);
    assign P       = p_q;

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Bench for booth4_seq_mult: directed vectors, handshake,
// abort/reset corners and a random sweep at N=8 and N=16.
module tb_booth4_seq_mult;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic        start8, abort8, sm8;
    logic [7:0]  a8, b8;
    logic        busy8, fin8;
    logic [15:0] p8;

    logic        start16, abort16, sm16;
    logic [15:0] a16, b16;
    logic        busy16, fin16;
    logic [31:0] p16;

    booth4_seq_mult #(.N(8)) u_dut8 (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (start8),
        .SIGNED_MODE (sm8),
        .ABORT       (abort8),
        .A           (a8),
        .B           (b8),
        .BUSY        (busy8),
        .FINMULT     (fin8),
        .P           (p8)
    );

    booth4_seq_mult #(.N(16)) u_dut16 (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (start16),
        .SIGNED_MODE (sm16),
        .ABORT       (abort16),
        .A           (a16),
        .B           (b16),
        .BUSY        (busy16),
        .FINMULT     (fin16),
        .P           (p16)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h",
                     nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref8(
        input logic [7:0] a, input logic [7:0] b,
        input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 16'(x * y);
    endfunction

    function automatic logic [31:0] ref16(
        input logic [15:0] a, input logic [15:0] b,
        input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 32'(x * y);
    endfunction

    // One full handshake on the N=8 instance; inputs are
    // scrambled after capture to show they are not re-read.
    task automatic op8(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic s,
                       output logic [15:0] p,
                       output int lat);
        @(negedge CLK);
        a8 = a; b8 = b; sm8 = s; start8 = 1'b1;
        @(posedge CLK);
        #1;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        sm8 = 1'($urandom);
        lat = 0;
        do begin
            @(posedge CLK);
            #1;
            lat++;
        end while (!fin8 && lat < 100);
        p = p8;
        @(negedge CLK);
        start8 = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic op16(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic s,
                        output logic [31:0] p,
                        output int lat);
        @(negedge CLK);
        a16 = a; b16 = b; sm16 = s; start16 = 1'b1;
        @(posedge CLK);
        #1;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        lat = 0;
        do begin
            @(posedge CLK);
            #1;
            lat++;
        end while (!fin16 && lat < 100);
        p = p16;
        @(negedge CLK);
        start16 = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [15:0] r8;
        logic [31:0] r16;
        int          lat;
        int          rises;
        int          fins;
        logic        prev;
        logic [7:0]  ra, rb;
        logic [15:0] ra16, rb16;
        logic        rs;

        vecs[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[3] = '{8'h7F, 8'hFF, 1'b1, 16'hFF81};
        vecs[4] = '{8'h00, 8'hA5, 1'b1, 16'h0000};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 16'h4000};
        vecs[6] = '{8'h7F, 8'h7F, 1'b0, 16'h3F01};

        RESET = 1'b0;
        start8 = 0; abort8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        start16 = 0; abort16 = 0; sm16 = 0;
        a16 = 0; b16 = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_p", 64'(p8), 64'h0);
        chk("rst_busy", 64'(busy8), 64'h0);
        chk("rst_fin", 64'(fin8), 64'h0);
        @(negedge CLK);
        RESET = 1'b1;

        for (int i = 0; i < 7; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].s, r8, lat);
            chk($sformatf("vec%0d_p", i),
                64'(r8), 64'(vecs[i].p));
            chk($sformatf("vec%0d_lat", i),
                64'(lat), 64'd11);
        end

        // START held for 20 cycles: one result, FINMULT from 11.
        @(negedge CLK);
        a8 = 8'h80; b8 = 8'h80; sm8 = 1'b1; start8 = 1'b1;
        @(posedge CLK);
        rises = 0;
        prev = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("hold_fin%0d", c),
                64'(fin8), 64'(c >= 11));
            chk($sformatf("hold_busy%0d", c),
                64'(busy8), 64'(c < 11));
            if (fin8 && !prev) rises++;
            prev = fin8;
        end
        chk("hold_p", 64'(p8), 64'h4000);
        @(negedge CLK);
        start8 = 1'b0;
        @(posedge CLK);
        #1;
        chk("hold_drop", 64'(fin8), 64'h0);
        chk("hold_rises", 64'(rises), 64'd1);

        // ABORT during the 4th OP.
        op8(8'hFF, 8'hFF, 1'b0, r8, lat);
        chk("pre_abort_p", 64'(r8), 64'hFE01);
        @(negedge CLK);
        a8 = 8'h12; b8 = 8'h34; sm8 = 1'b0; start8 = 1'b1;
        @(posedge CLK);
        repeat (7) @(posedge CLK);
        #1;
        chk("op4_busy", 64'(busy8), 64'h1);
        @(negedge CLK);
        abort8 = 1'b1;
        start8 = 1'b0;
        @(posedge CLK);
        #1;
        chk("abort_busy", 64'(busy8), 64'h0);
        chk("abort_fin", 64'(fin8), 64'h0);
        chk("abort_p", 64'(p8), 64'hFE01);
        @(negedge CLK);
        abort8 = 1'b0;
        fins = 0;
        repeat (15) begin
            @(posedge CLK);
            #1;
            if (fin8) fins++;
        end
        chk("abort_nofin", 64'(fins), 64'h0);

        // ABORT beats START in IDLE, then START restarts.
        @(negedge CLK);
        abort8 = 1'b1; start8 = 1'b1;
        a8 = 8'h11; b8 = 8'h0D; sm8 = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("abst_busy", 64'(busy8), 64'h0);
        @(negedge CLK);
        abort8 = 1'b0;
        lat = 0;
        do begin
            @(posedge CLK);
            #1;
            lat++;
        end while (!fin8 && lat < 100);
        chk("restart_lat", 64'(lat), 64'd12);
        chk("restart_p", 64'(p8), 64'h00DD);
        @(negedge CLK);
        start8 = 1'b0;
        @(posedge CLK);
        #1;

        // Async reset pulse while in the first SHIFT.
        @(negedge CLK);
        a8 = 8'h05; b8 = 8'h07; start8 = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk("rst_mid_p", 64'(p8), 64'h0);
        chk("rst_mid_busy", 64'(busy8), 64'h0);
        chk("rst_mid_fin", 64'(fin8), 64'h0);
        @(negedge CLK);
        RESET = 1'b1;
        start8 = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_idle", 64'(busy8), 64'h0);

        // N=16 corner.
        op16(16'h8000, 16'h7FFF, 1'b1, r16, lat);
        chk("n16_p", 64'(r16), 64'hC0008000);
        chk("n16_lat", 64'(lat), 64'd19);

        // Random sweep against the arithmetic model.
        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            op8(ra, rb, rs, r8, lat);
            chk($sformatf("rnd8_%0d %h*%h s%0d", i, ra, rb, rs),
                64'(r8), 64'(ref8(ra, rb, rs)));
            chk("rnd8_lat", 64'(lat), 64'd11);
        end
        for (int i = 0; i < 300; i++) begin
            ra16 = 16'($urandom);
            rb16 = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            op16(ra16, rb16, rs, r16, lat);
            chk($sformatf("rnd16_%0d %h*%h s%0d",
                          i, ra16, rb16, rs),
                64'(r16), 64'(ref16(ra16, rb16, rs)));
            chk("rnd16_lat", 64'(lat), 64'd19);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
